// File: rtl/ijtag_tdr_pkg.sv
// Shared definitions for the IJTAG SIB/TDR family: register sizing, default masks and the
// shift-register operation priority.
package ijtag_tdr_pkg;

  localparam int unsigned MAX_TDR_WIDTH = 256;

  typedef logic [MAX_TDR_WIDTH-1:0] tdr_mask_t;

  typedef enum logic [1:0] {
    TdrHold    = 2'd0,
    TdrShift   = 2'd1,
    TdrCapture = 2'd2,
    TdrReset   = 2'd3
  } tdr_op_e;

  function automatic int unsigned tdr_len(input int unsigned do_width,
                                          input int unsigned di_width);
    return do_width + di_width;
  endfunction

  // Zero-width fields still need a legal 1-bit port.
  function automatic int unsigned port_width(input int unsigned width);
    return (width == 0) ? 1 : width;
  endfunction

  function automatic tdr_mask_t zero_mask();
    return '0;
  endfunction

  // Reset beats capture, capture beats shift; a deselected register holds.
  function automatic tdr_op_e tdr_op(input logic reset, input logic sel, input logic ce,
                                     input logic se);
    if (reset) return TdrReset;
    if (sel && ce) return TdrCapture;
    if (sel && se) return TdrShift;
    return TdrHold;
  endfunction

endpackage

// File: rtl/ijtag_tdr_sticky_status.sv
// Status capture field: live bits pass straight through, sticky bits OR-accumulate between
// captures and restart from the capture-cycle input so coincident events are not lost.
module ijtag_tdr_sticky_status
  import ijtag_tdr_pkg::*;
#(
  parameter int unsigned         DI_WIDTH       = 8,
  parameter logic [DI_WIDTH-1:0] DI_STICKY_MASK = DI_WIDTH'(zero_mask())
) (
  input  logic                ijtag_tck,
  input  logic                ijtag_reset,
  input  logic                capture,
  input  logic [DI_WIDTH-1:0] data_in,
  output logic [DI_WIDTH-1:0] status_cap
);

  logic [DI_WIDTH-1:0] sticky_q;
  logic [DI_WIDTH-1:0] sticky_d;

  always_comb begin
    sticky_d = (sticky_q | data_in) & DI_STICKY_MASK;
    if (capture) begin
      sticky_d = data_in & DI_STICKY_MASK;
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign status_cap = (data_in & ~DI_STICKY_MASK) | ((sticky_q | data_in) & DI_STICKY_MASK);

endmodule

// File: rtl/ijtag_tdr_param_ctrl.sv
// Parametrised IJTAG control/status TDR: data_out readback plus optional status field, with
// per-bit reset values, self-clearing pulse bits and an update strobe.
module ijtag_tdr_param_ctrl
  import ijtag_tdr_pkg::*;
#(
  parameter int unsigned           DO_WIDTH       = 20,
  parameter int unsigned           DI_WIDTH       = 8,
  localparam int unsigned          DI_W           = port_width(DI_WIDTH),
  parameter logic [DO_WIDTH-1:0]   DO_RESET_VALUE = DO_WIDTH'(zero_mask()),
  parameter logic [DO_WIDTH-1:0]   DO_PULSE_MASK  = DO_WIDTH'(zero_mask()),
  parameter logic [DI_W-1:0]       DI_STICKY_MASK = DI_W'(zero_mask())
) (
  input  logic                ijtag_tck,
  input  logic                ijtag_reset,
  input  logic                ijtag_sel,
  input  logic                ijtag_si,
  input  logic                ijtag_ce,
  input  logic                ijtag_se,
  input  logic                ijtag_ue,
  input  logic [DI_W-1:0]     data_in,
  output logic [DO_WIDTH-1:0] data_out,
  output logic                data_out_updated,
  output logic                ijtag_so
);

  localparam int unsigned N = tdr_len(DO_WIDTH, DI_WIDTH);

  logic [N-1:0]        tdr_q;
  logic [N-1:0]        tdr_d;
  logic [N-1:0]        capture_word;
  logic [DO_WIDTH-1:0] data_out_q;
  logic [DO_WIDTH-1:0] data_out_d;
  logic                updated_q;
  logic                so_q;
  logic                capture;
  logic                update;

  assign capture = ijtag_sel & ijtag_ce;
  assign update  = ijtag_sel & ijtag_ue;

  if (DI_WIDTH > 0) begin : g_status
    logic [DI_WIDTH-1:0] status_cap;

    ijtag_tdr_sticky_status #(
      .DI_WIDTH       (DI_WIDTH),
      .DI_STICKY_MASK (DI_STICKY_MASK)
    ) u_sticky_status (
      .ijtag_tck   (ijtag_tck),
      .ijtag_reset (ijtag_reset),
      .capture     (capture),
      .data_in     (data_in),
      .status_cap  (status_cap)
    );

    assign capture_word = {status_cap, data_out_q};
  end else begin : g_no_status
    logic unused_data_in;
    assign unused_data_in = ^data_in;
    assign capture_word   = data_out_q;
  end

  always_comb begin
    tdr_d = tdr_q;
    unique case (tdr_op(ijtag_reset, ijtag_sel, ijtag_ce, ijtag_se))
      TdrReset:   tdr_d = '0;
      TdrCapture: tdr_d = capture_word;
      // Concatenate-and-shift keeps the single-bit register legal.
      TdrShift:   tdr_d = N'({ijtag_si, tdr_q} >> 1);
      default:    tdr_d = tdr_q;
    endcase
  end

  always_comb begin
    data_out_d = data_out_q;
    if (update) begin
      data_out_d = tdr_q[DO_WIDTH-1:0];
    end else if (updated_q) begin
      data_out_d = (data_out_q & ~DO_PULSE_MASK) | (DO_RESET_VALUE & DO_PULSE_MASK);
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      tdr_q      <= '0;
      data_out_q <= DO_RESET_VALUE;
      updated_q  <= 1'b0;
    end else begin
      tdr_q      <= tdr_d;
      data_out_q <= data_out_d;
      updated_q  <= update;
    end
  end

  // Half-cycle retiming for hold margin on the downstream scan segment.
  always_ff @(negedge ijtag_tck) begin
    so_q <= tdr_q[0];
  end

  assign data_out         = data_out_q;
  assign data_out_updated = updated_q;
  assign ijtag_so         = so_q;

endmodule

// File: tb/tb_ijtag_tdr_param_ctrl.sv
// Self-checking bench: directed table/sequence checks plus randomized traffic against a
// behavioural model of the TDR.
module tb_ijtag_tdr_param_ctrl;

  localparam int unsigned DO_W    = 20;
  localparam int unsigned DI_W    = 8;
  localparam int unsigned N       = DO_W + DI_W;
  localparam logic [19:0] RST_VAL = 20'h00005;
  localparam logic [19:0] PULSE   = 20'h00002;
  localparam logic [7:0]  STICKY  = 8'h01;

  logic        tck = 1'b0;
  logic        reset, sel, si, ce, se, ue;
  logic [7:0]  din;
  logic [19:0] data_out;
  logic        upd;
  logic        so;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [N-1:0] m_tdr;
  logic [19:0]  m_do;
  logic         m_upd;
  logic         m_pulse_armed;
  logic [7:0]   m_events;

  ijtag_tdr_param_ctrl #(
    .DO_WIDTH       (DO_W),
    .DI_WIDTH       (DI_W),
    .DO_RESET_VALUE (RST_VAL),
    .DO_PULSE_MASK  (PULSE),
    .DI_STICKY_MASK (STICKY)
  ) dut (
    .ijtag_tck        (tck),
    .ijtag_reset      (reset),
    .ijtag_sel        (sel),
    .ijtag_si         (si),
    .ijtag_ce         (ce),
    .ijtag_se         (se),
    .ijtag_ue         (ue),
    .data_in          (din),
    .data_out         (data_out),
    .data_out_updated (upd),
    .ijtag_so         (so)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model works from the rules: events seen since the last capture are remembered for the
  // sticky bits, captures report {status, current controls}, shifts move toward scan-out.
  task automatic model_step();
    logic [N-1:0] old_tdr;
    logic [7:0]   status;
    old_tdr = m_tdr;
    if (reset) begin
      m_tdr = '0;
      m_do = RST_VAL;
      m_upd = 1'b0;
      m_pulse_armed = 1'b0;
      m_events = '0;
    end else begin
      status = din | (m_events & STICKY);
      if (sel && ce) begin
        m_tdr = {status, m_do};
        m_events = din & STICKY;
      end else begin
        m_events = (m_events | din) & STICKY;
        if (sel && se) m_tdr = (m_tdr >> 1) + (N'(si) << (N - 1));
      end
      if (sel && ue) begin
        m_do = old_tdr[19:0];
        m_pulse_armed = 1'b1;
      end else if (m_pulse_armed) begin
        for (int b = 0; b < 20; b++) if (PULSE[b]) m_do[b] = RST_VAL[b];
        m_pulse_armed = 1'b0;
      end
      m_upd = sel && ue;
    end
  endtask

  task automatic tick();
    @(posedge tck);
    model_step();
    #1;
    chk("data_out_model", 64'(data_out), 64'(m_do));
    chk("updated_model", 64'(upd), 64'(m_upd));
    @(negedge tck);
    #1;
    chk("so_model", 64'(so), 64'(m_tdr[0]));
  endtask

  task automatic idle();
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0; din = '0;
  endtask

  task automatic scan(input bit cap, input logic [7:0] cap_din, input logic [N-1:0] sin,
                      output logic [N-1:0] sout);
    if (cap) begin
      sel = 1'b1; ce = 1'b1; din = cap_din;
      tick();
      ce = 1'b0; din = '0;
    end
    sel = 1'b1; se = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      sout[i] = so;
      si = sin[i];
      tick();
    end
    idle();
  endtask

  typedef struct {
    logic [N-1:0] shift_val;
    logic [19:0]  exp_now;
    logic [19:0]  exp_after;
  } upd_vec_t;

  upd_vec_t vecs[4];
  logic [N-1:0] rd;
  logic [19:0]  saved_do;

  initial begin
    vecs[0] = '{28'h0A_BCDE1, 20'hBCDE1, 20'hBCDE1};
    vecs[1] = '{28'hF0_00002, 20'h00002, 20'h00000};
    vecs[2] = '{28'h00_FFFFF, 20'hFFFFF, 20'hFFFFD};
    vecs[3] = '{28'h55_00000, 20'h00000, 20'h00000};

    idle();
    reset = 1'b1;
    m_tdr = '0; m_do = RST_VAL; m_upd = 1'b0; m_pulse_armed = 1'b0; m_events = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_data_out", 64'(data_out), 64'h5);
    chk("reset_updated", 64'(upd), 64'h0);
    scan(1'b1, 8'h00, '0, rd);
    chk("reset_readback", 64'(rd), 64'h0000005);

    // Update table: status field never reaches data_out, pulse bit 1 clears next cycle
    foreach (vecs[k]) begin
      scan(1'b0, 8'h00, vecs[k].shift_val, rd);
      sel = 1'b1; ue = 1'b1;
      tick();
      ue = 1'b0;
      chk("upd_now", 64'(data_out), 64'(vecs[k].exp_now));
      chk("upd_strobe", 64'(upd), 64'h1);
      tick();
      chk("upd_after", 64'(data_out), 64'(vecs[k].exp_after));
      chk("upd_strobe_off", 64'(upd), 64'h0);
      idle();
    end

    // Back-to-back updates keep the pulse bit high for two cycles
    scan(1'b0, 8'h00, 28'h0000002, rd);
    sel = 1'b1; ue = 1'b1;
    tick();
    chk("pulse_c1", 64'(data_out[1]), 64'h1);
    tick();
    chk("pulse_c2", 64'(data_out[1]), 64'h1);
    ue = 1'b0;
    tick();
    chk("pulse_c3", 64'(data_out[1]), 64'h0);
    idle();

    // Sticky bit 0
    din = 8'h01;
    tick();
    din = 8'h00;
    repeat (10) tick();
    scan(1'b1, 8'h00, '0, rd);
    chk("sticky_held", 64'(rd[20]), 64'h1);
    scan(1'b1, 8'h00, '0, rd);
    chk("sticky_cleared", 64'(rd[20]), 64'h0);
    scan(1'b1, 8'h01, '0, rd);
    chk("sticky_cap_now", 64'(rd[20]), 64'h1);
    scan(1'b1, 8'h00, '0, rd);
    chk("sticky_cap_kept", 64'(rd[20]), 64'h1);

    // Non-sticky bit 7 is live only
    scan(1'b1, 8'h80, '0, rd);
    chk("live_in_cap", 64'(rd[27]), 64'h1);
    din = 8'h80;
    tick();
    din = 8'h00;
    scan(1'b1, 8'h00, '0, rd);
    chk("live_before_cap", 64'(rd[27]), 64'h0);

    // Deselected register ignores ce/se/ue
    scan(1'b0, 8'h00, 28'h9_3C5A6, rd);
    saved_do = data_out;
    for (int i = 0; i < 20; i++) begin
      sel = 1'b0; ce = 1'($urandom); se = 1'($urandom); ue = 1'($urandom); si = 1'($urandom);
      tick();
    end
    idle();
    chk("desel_data_out", 64'(data_out), 64'(saved_do));
    scan(1'b0, 8'h00, '0, rd);
    chk("desel_tdr", 64'(rd), 64'h9_3C5A6);

    // Reset mid-shift with an update pending its pulse clear
    scan(1'b0, 8'h00, 28'h00_FFFFF, rd);
    sel = 1'b1; ue = 1'b1;
    tick();
    ue = 1'b0; se = 1'b1; si = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midrst_data_out", 64'(data_out), 64'h5);
    chk("midrst_updated", 64'(upd), 64'h0);
    chk("midrst_so", 64'(so), 64'h0);
    reset = 1'b0;
    idle();
    tick();
    chk("midrst_hold", 64'(data_out), 64'h5);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      sel   = ($urandom_range(0, 9) != 0);
      ce    = ($urandom_range(0, 15) == 0);
      se    = 1'($urandom);
      ue    = ($urandom_range(0, 6) == 0);
      si    = 1'($urandom);
      din   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
